// File: rtl/mic_sample_conditioner_if.sv
// rtl/mic_sample_conditioner_if.sv - sample input strobe and conditioned output valid/ready stream
interface mic_sample_conditioner_if #(
    parameter int W = 16
);
    logic signed [W-1:0] in_data;
    logic                in_valid;
    logic signed [W-1:0] out_data;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output out_data, out_valid
    );
endinterface

// File: rtl/mic_sample_conditioner.sv
// rtl/mic_sample_conditioner.sv - DC removal, boxcar decimation and show-ahead output FIFO
// Optional DC-blocking IIR stage enabled by defining MIC_DC_BLOCK_EN.
module mic_sample_conditioner #(
    parameter int W          = 16,
    parameter int DECIM_LOG2 = 1,
    parameter int FIFO_DEPTH = 8,
    parameter int DC_SHIFT   = 8
) (
    input  logic                            audio_clk,
    input  logic                            reset,
    mic_sample_conditioner_if.slave         io,
    input  logic                            flush,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [15:0]                     overflow_count,
    output logic                            overflow
);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int LW     = AW + 1;
    localparam int N      = 1 << DECIM_LOG2;
    localparam int ACC_W  = W + DECIM_LOG2;
    localparam int CW     = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic signed [W-1:0]     y_q, y_d, y_next;
    logic                    y_vld_q, y_vld_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, sum;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    push_vld_q, push_vld_d;
    logic signed [W-1:0]     push_data_q, push_data_d;
    logic signed [W-1:0]     mem_q [FIFO_DEPTH];
    logic signed [W-1:0]     mem_d [FIFO_DEPTH];
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]           level_q, level_d;
    logic [15:0]             ovf_cnt_q, ovf_cnt_d;
    logic                    ovf_q, ovf_d;
    logic                    pop, accept, drop;

`ifdef MIC_DC_BLOCK_EN
    localparam int DC_W = W + DC_SHIFT + 1;
    localparam int DF_W = DC_W + 1;
    logic signed [DC_W-1:0] dc_acc_q, dc_acc_d, dc_est;
    logic signed [DF_W-1:0] diff;

    // diff is wide enough to hold any input minus any estimate; clamp back to W bits
    always_comb begin
        dc_est   = dc_acc_q >>> DC_SHIFT;
        diff     = DF_W'(io.in_data) - DF_W'(dc_est);
        dc_acc_d = DC_W'(DF_W'(dc_acc_q) + diff);
        if (diff[DF_W-1:W-1] == {(DF_W-W+1){diff[DF_W-1]}}) begin
            y_next = diff[W-1:0];
        end else if (diff[DF_W-1]) begin
            y_next = {1'b1, {(W-1){1'b0}}};
        end else begin
            y_next = {1'b0, {(W-1){1'b1}}};
        end
    end
`else
    always_comb begin
        y_next = io.in_data;
    end
`endif

    always_comb begin
        pop         = (level_q != '0) && io.out_ready;
        accept      = push_vld_q && ((level_q < DEPTH_L) || pop);
        drop        = push_vld_q && !accept;
        sum         = acc_q + ACC_W'(y_q);
        y_d         = y_q;
        y_vld_d     = 1'b0;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        push_vld_d  = 1'b0;
        push_data_d = push_data_q;
        mem_d       = mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        level_d     = level_q;
        ovf_cnt_d   = ovf_cnt_q;
        ovf_d       = ovf_q;
        if (flush) begin
            acc_d    = '0;
            cnt_d    = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (io.in_valid) begin
                y_d     = y_next;
                y_vld_d = 1'b1;
            end
            if (y_vld_q) begin
                if (cnt_q == CNT_LAST) begin
                    push_vld_d  = 1'b1;
                    push_data_d = W'(sum >>> DECIM_LOG2);
                    acc_d       = '0;
                    cnt_d       = '0;
                end else begin
                    acc_d = sum;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (accept) begin
                mem_d[wr_ptr_q] = push_data_q;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (accept && !pop) begin
                level_d = level_q + LW'(1);
            end else if (!accept && pop) begin
                level_d = level_q - LW'(1);
            end
            if (drop) begin
                ovf_d = 1'b1;
                if (ovf_cnt_q != 16'hFFFF) begin
                    ovf_cnt_d = ovf_cnt_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge audio_clk or posedge reset) begin
        if (reset) begin
            y_q         <= '0;
            y_vld_q     <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            push_vld_q  <= 1'b0;
            push_data_q <= '0;
            mem_q       <= '{default: '0};
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            ovf_cnt_q   <= '0;
            ovf_q       <= 1'b0;
`ifdef MIC_DC_BLOCK_EN
            dc_acc_q    <= '0;
`endif
        end else begin
            y_q         <= y_d;
            y_vld_q     <= y_vld_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            push_vld_q  <= push_vld_d;
            push_data_q <= push_data_d;
            mem_q       <= mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            level_q     <= level_d;
            ovf_cnt_q   <= ovf_cnt_d;
            ovf_q       <= ovf_d;
`ifdef MIC_DC_BLOCK_EN
            if (!flush && io.in_valid) begin
                dc_acc_q <= dc_acc_d;
            end
`endif
        end
    end

    assign io.out_valid   = (level_q != '0);
    assign io.out_data    = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign fifo_level     = level_q;
    assign overflow_count = ovf_cnt_q;
    assign overflow       = ovf_q;
endmodule
